// File: rtl/mac_seq_ctrl.sv
// Multi-pair load/multiply/store sequencer for the register-file / multiplier / RAM datapath.
// Optional READ_RAM sweep of the written region is compiled in when READBACK_EN is defined.
`timescale 1ns/1ps

module mac_seq_ctrl #(
    parameter int ADDR_W  = 3,
    parameter int RAM_AW  = 4,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] adr1_i,
    input  logic [ADDR_W-1:0] adr2_i,
    input  logic [RAM_AW-1:0] ram_base_i,
    input  logic [ADDR_W:0]   n_pairs_i,
    output logic              w_rf_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic              da_o,
    output logic              sa_o,
    output logic              sb_o,
    output logic              w_ram_o,
    output logic [RAM_AW-1:0] ram_adr_o,
    output logic              rd_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        st_out_o
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_A    = 4'd1,
        LOAD_B    = 4'd2,
        MULTIPLY  = 4'd3,
        WRITE_RAM = 4'd4,
        READ_RAM  = 4'd5,
        DONE      = 4'd6
    } state_t;

    localparam int                WAIT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MUL_LAT - 1);
    localparam logic [WAIT_W-1:0] ONE_W     = 1;
    localparam logic [ADDR_W-1:0] ONE_I     = 1;
    localparam logic [ADDR_W:0]   ONE_N     = 1;
    localparam logic [ADDR_W:0]   N_MAX     = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   adr1_q, adr1_d;
    logic [ADDR_W-1:0]   adr2_q, adr2_d;
    logic [RAM_AW-1:0]   base_q, base_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic                idxLast;
    logic [RAM_AW-1:0]   ramAdr;

    // idx never exceeds n-1, so the extended idx+1 matching n marks the final pair
    assign idxLast = (({1'b0, idx_q} + ONE_N) == n_q);
    assign ramAdr  = base_q + RAM_AW'(idx_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            adr1_q  <= '0;
            adr2_q  <= '0;
            base_q  <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            adr1_q  <= adr1_d;
            adr2_q  <= adr2_d;
            base_q  <= base_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        adr1_d  = adr1_q;
        adr2_d  = adr2_q;
        base_d  = base_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    adr1_d  = adr1_i;
                    adr2_d  = adr2_i;
                    base_d  = ram_base_i;
                    n_d     = (n_pairs_i > N_MAX) ? N_MAX : n_pairs_i;
                    idx_d   = '0;
                    wait_d  = '0;
                    state_d = (n_pairs_i == '0) ? DONE : LOAD_A;
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: begin
                wait_d  = '0;
                state_d = MULTIPLY;
            end
            MULTIPLY: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = WRITE_RAM;
                end else begin
                    wait_d = wait_q + ONE_W;
                end
            end
            WRITE_RAM: begin
                if (idxLast) begin
                    idx_d   = '0;
`ifdef READBACK_EN
                    state_d = READ_RAM;
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx_q + ONE_I;
                    state_d = LOAD_A;
                end
            end
            READ_RAM: begin
                if (idxLast) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + ONE_I;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls are pure decodes of the registered state, so reset clears them at once
    always_comb begin
        w_rf_o     = 1'b0;
        adr_o      = '0;
        da_o       = 1'b0;
        sa_o       = 1'b0;
        sb_o       = 1'b0;
        w_ram_o    = 1'b0;
        ram_adr_o  = '0;
        rd_valid_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            LOAD_A: begin
                w_rf_o = 1'b1;
                adr_o  = adr1_q + idx_q;
                sb_o   = 1'b1;
            end
            LOAD_B: begin
                w_rf_o = 1'b1;
                adr_o  = adr2_q + idx_q;
                da_o   = 1'b1;
                sb_o   = 1'b1;
            end
            WRITE_RAM: begin
                w_ram_o   = 1'b1;
                ram_adr_o = ramAdr;
            end
            READ_RAM: begin
`ifdef READBACK_EN
                rd_valid_o = 1'b1;
                ram_adr_o  = ramAdr;
`endif
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o   = (state_q != IDLE);
    assign st_out_o = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: one instance at MUL_LAT=1, one at MUL_LAT=3.
// Follows READBACK_EN the same way the design does.
`timescale 1ns/1ps

module tb_mac_seq_ctrl;

`ifdef READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct packed {
        int         cyc;
        logic [3:0] st;
        logic       wrf;
        logic [2:0] adr;
        logic       da;
        logic       sa;
        logic       sb;
        logic       wram;
        logic [3:0] radr;
        logic       rdv;
        logic       dn;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startA = 1'b0;
    logic       startB = 1'b0;
    logic [2:0] adr1 = '0;
    logic [2:0] adr2 = '0;
    logic [3:0] ramBase = '0;
    logic [3:0] nPairs = '0;

    logic       wRfA, daA, saA, sbA, wRamA, rdValidA, busyA, doneA;
    logic [2:0] adrA;
    logic [3:0] ramAdrA, stA;
    logic       wRfB, daB, saB, sbB, wRamB, rdValidB, busyB, doneB;
    logic [2:0] adrB;
    logic [3:0] ramAdrB, stB;

    ev_t qA[$];
    ev_t qB[$];
    int  nChecks = 0;
    int  nPass = 0;
    int  cnt = 0;
    int  doneCycA = -1;
    int  doneCycB = -1;

    mac_seq_ctrl #(.ADDR_W(3), .RAM_AW(4), .MUL_LAT(1)) dutA (
        .clk(clk), .reset(reset), .start_i(startA), .adr1_i(adr1), .adr2_i(adr2),
        .ram_base_i(ramBase), .n_pairs_i(nPairs), .w_rf_o(wRfA), .adr_o(adrA),
        .da_o(daA), .sa_o(saA), .sb_o(sbA), .w_ram_o(wRamA), .ram_adr_o(ramAdrA),
        .rd_valid_o(rdValidA), .busy_o(busyA), .done_o(doneA), .st_out_o(stA)
    );

    mac_seq_ctrl #(.ADDR_W(3), .RAM_AW(4), .MUL_LAT(3)) dutB (
        .clk(clk), .reset(reset), .start_i(startB), .adr1_i(adr1), .adr2_i(adr2),
        .ram_base_i(ramBase), .n_pairs_i(nPairs), .w_rf_o(wRfB), .adr_o(adrB),
        .da_o(daB), .sa_o(saB), .sb_o(sbB), .w_ram_o(wRamB), .ram_adr_o(ramAdrB),
        .rd_valid_o(rdValidB), .busy_o(busyB), .done_o(doneB), .st_out_o(stB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    function automatic ev_t mk(input int c, input logic [3:0] st, input logic wrf,
                               input logic [2:0] adr, input logic da, input logic sa,
                               input logic sb, input logic wram, input logic [3:0] radr,
                               input logic rdv, input logic dn);
        ev_t e;
        e.cyc = c; e.st = st; e.wrf = wrf; e.adr = adr; e.da = da; e.sa = sa;
        e.sb = sb; e.wram = wram; e.radr = radr; e.rdv = rdv; e.dn = dn;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // Expected per-cycle picture of a run whose start is sampled on the edge after cycle count s
    task automatic pushRun(input bit inst, input logic [2:0] a1, input logic [2:0] a2,
                           input logic [3:0] base, input logic [3:0] nReq, input int lat,
                           input int s, input int lastK);
        ev_t run[$];
        int  n = (nReq > 4'd8) ? 8 : int'(nReq);
        int  k = 1;
        for (int i = 0; i < n; i++) begin
            run.push_back(mk(s + k, 4'd1, 1'b1, a1 + 3'(i), 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0)); k++;
            run.push_back(mk(s + k, 4'd2, 1'b1, a2 + 3'(i), 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0)); k++;
            for (int w = 0; w < lat; w++) begin
                run.push_back(mk(s + k, 4'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0)); k++;
            end
            run.push_back(mk(s + k, 4'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, base + 4'(i), 1'b0, 1'b0)); k++;
        end
        if (RB) begin
            for (int i = 0; i < n; i++) begin
                run.push_back(mk(s + k, 4'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, base + 4'(i), 1'b1, 1'b0)); k++;
            end
        end
        run.push_back(mk(s + k, 4'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
        foreach (run[j]) begin
            if (run[j].cyc <= s + lastK) begin
                if (inst) qB.push_back(run[j]);
                else qA.push_back(run[j]);
            end
        end
    endtask

    task automatic applyStimulus(input bit inst, input logic [2:0] a1, input logic [2:0] a2,
                                 input logic [3:0] base, input logic [3:0] n, input bit hold,
                                 output int s);
        @(negedge clk);
        adr1 = a1; adr2 = a2; ramBase = base; nPairs = n;
        if (inst) startB = 1'b1;
        else startA = 1'b1;
        s = cnt;
        if (inst) doneCycB = -1;
        else doneCycA = -1;
        if (!hold) begin
            @(negedge clk);
            startA = 1'b0;
            startB = 1'b0;
        end
    endtask

    // Wait for the monitor to consume every expected entry, then confirm the instance is idle
    task automatic drain(input bit inst, input int budget);
        int t = 0;
        while (((inst ? qB.size() : qA.size()) != 0) && (t < budget)) begin
            @(negedge clk);
            t++;
        end
        if ((inst ? qB.size() : qA.size()) != 0) begin
            nChecks++;
            $display("[TB] FAIL drain%0d timeout, %0d entries left", inst, inst ? qB.size() : qA.size());
            if (inst) qB.delete();
            else qA.delete();
        end
        @(negedge clk);
        #1;
        checkOutput(inst ? "idleStB" : "idleStA", 64'(inst ? stB : stA), 64'd0);
    endtask

    always @(negedge clk) begin : monA
        ev_t act, e;
        if (!reset && busyA) begin
            act = mk(cnt, stA, wRfA, adrA, daA, saA, sbA, wRamA, ramAdrA, rdValidA, doneA);
            if (doneA) doneCycA = cnt;
            if (qA.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL scoreA unexpected activity cyc=%0d st=%0d", cnt, stA);
            end else begin
                e = qA.pop_front();
                checkOutput("scoreA", 64'(act), 64'(e));
            end
        end
    end

    always @(negedge clk) begin : monB
        ev_t act, e;
        if (!reset && busyB) begin
            act = mk(cnt, stB, wRfB, adrB, daB, saB, sbB, wRamB, ramAdrB, rdValidB, doneB);
            if (doneB) doneCycB = cnt;
            if (qB.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL scoreB unexpected activity cyc=%0d st=%0d", cnt, stB);
            end else begin
                e = qB.pop_front();
                checkOutput("scoreB", 64'(act), 64'(e));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin : stim
        int s, s2, wramSeen, d1;
        #1;
        checkOutput("rstA", 64'({wRfA, adrA, daA, saA, sbA, wRamA, ramAdrA, rdValidA, busyA, doneA, stA}), 64'd0);
        checkOutput("rstB", 64'({wRfB, adrB, daB, saB, sbB, wRamB, ramAdrB, rdValidB, busyB, doneB, stB}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("noStartIdle", 64'(stA), 64'd0);

        $display("[TB] single pair");
        applyStimulus(1'b0, 3'd1, 3'd4, 4'd2, 4'd1, 1'b0, s);
        pushRun(1'b0, 3'd1, 3'd4, 4'd2, 4'd1, 1, s, 1000);
        drain(1'b0, 40);
        checkOutput("doneCycSingle", 64'(doneCycA - s), RB ? 64'd6 : 64'd5);

        $display("[TB] wrap-around");
        applyStimulus(1'b0, 3'd6, 3'd7, 4'd14, 4'd3, 1'b0, s);
        pushRun(1'b0, 3'd6, 3'd7, 4'd14, 4'd3, 1, s, 1000);
        drain(1'b0, 60);
        checkOutput("doneCycWrap", 64'(doneCycA - s), RB ? 64'd16 : 64'd13);

        $display("[TB] zero count");
        applyStimulus(1'b0, 3'd2, 3'd3, 4'd1, 4'd0, 1'b0, s);
        pushRun(1'b0, 3'd2, 3'd3, 4'd1, 4'd0, 1, s, 1000);
        drain(1'b0, 20);
        checkOutput("doneCycZero", 64'(doneCycA - s), 64'd1);

        $display("[TB] saturated count");
        applyStimulus(1'b0, 3'd0, 3'd0, 4'd0, 4'd15, 1'b0, s);
        pushRun(1'b0, 3'd0, 3'd0, 4'd0, 4'd15, 1, s, 1000);
        drain(1'b0, 100);
        checkOutput("doneCycSat", 64'(doneCycA - s), RB ? 64'd41 : 64'd33);

        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 3'd1, 3'd2, 4'd3, 4'd4, 1'b0, s);
        pushRun(1'b0, 3'd1, 3'd2, 4'd3, 4'd4, 1, s, 7);
        while (cnt < s + 7) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rstMidOutputs", 64'({wRfA, adrA, daA, saA, sbA, wRamA, ramAdrA, rdValidA, busyA, doneA}), 64'd0);
        checkOutput("rstMidSt", 64'(stA), 64'd0);
        checkOutput("rstMidConsumed", 64'(qA.size()), 64'd0);
        qA.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wramSeen = 0;
        repeat (12) begin
            @(negedge clk);
            if (wRamA) wramSeen++;
        end
        checkOutput("rstNoResume", 64'(wramSeen), 64'd0);
        checkOutput("rstStaysIdle", 64'(stA), 64'd0);

        $display("[TB] busy lockout");
        d1 = RB ? 11 : 9;
        applyStimulus(1'b0, 3'd3, 3'd0, 4'd5, 4'd2, 1'b1, s);
        s2 = s + d1 + 1;
        pushRun(1'b0, 3'd3, 3'd0, 4'd5, 4'd2, 1, s, 1000);
        pushRun(1'b0, 3'd5, 3'd0, 4'd5, 4'd2, 1, s2, 1000);
        repeat (2) @(negedge clk);
        adr1 = 3'd5;
        while (cnt < s2 + 1) @(negedge clk);
        startA = 1'b0;
        drain(1'b0, 60);
        checkOutput("doneCycRun2", 64'(doneCycA - s2), 64'(d1));

        $display("[TB] MUL_LAT=3 instance");
        applyStimulus(1'b1, 3'd2, 3'd5, 4'd9, 4'd2, 1'b0, s);
        pushRun(1'b1, 3'd2, 3'd5, 4'd9, 4'd2, 3, s, 1000);
        drain(1'b1, 60);
        checkOutput("doneCycLat3", 64'(doneCycB - s), RB ? 64'd15 : 64'd13);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Parametrised multi-pair sequencer for the register-file / multiplier / RAM datapath. On a start request it loads N operand pairs from the register file in turn, waits out the multiplier latency, and writes each product to consecutive RAM addresses. It can optionally sweep the written RAM region back out. It sits between the top-level user interface (switches/buttons) and the datapath control pins, replacing the single-pair control FSM.

## Interface
- ADDR_W, 3: register-file address width.
- RAM_AW, 4: RAM address width.
- MUL_LAT, 1: multiplier latency in cycles, ≥1.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  run request, sampled in IDLE only.
- adr1  in  ADDR_W  base address of operand A list.
- adr2  in  ADDR_W  base address of operand B list.
- ram_base  in  RAM_AW  first RAM write address.
- n_pairs  in  ADDR_W+1  pair count; values >2^ADDR_W saturate to 2^ADDR_W.
- w_rf  out  1  register-file write enable.
- adr  out  ADDR_W  register-file address.
- DA, SA, SB  out  1 each  datapath select lines.
- w_ram  out  1  RAM write enable.
- ram_adr  out  RAM_AW  RAM address.
- rd_valid  out  1  readback address valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- st_out  out  4  current state code.

## Operation
- States and codes: IDLE=0, LOAD_A=1, LOAD_B=2, MULTIPLY=3, WRITE_RAM=4, READ_RAM=5, DONE=6.
- IDLE with start=1:
  - Captures adr1, adr2, ram_base and saturated n_pairs into internal registers.
  - Clears the pair index idx and the wait counter.
  - Goes to LOAD_A, or to DONE if n_pairs==0.
- LOAD_A: w_rf=1, adr=adr1+idx, DA=0, SA=0, SB=1. Next state LOAD_B.
- LOAD_B: w_rf=1, adr=adr2+idx, DA=1, SA=0, SB=1. Next state MULTIPLY.
- MULTIPLY: stays MUL_LAT cycles (internal counter), then goes to WRITE_RAM.
- WRITE_RAM: w_ram=1, ram_adr=ram_base+idx.
  - If idx==n-1: clear idx, go to READ_RAM.
  - Otherwise: increment idx, go to LOAD_A.
- READ_RAM: rd_valid=1, ram_adr=ram_base+idx, one address per cycle.
  - If idx==n-1: go to DONE.
  - Otherwise: increment idx.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic: adr wraps modulo 2^ADDR_W; ram_adr wraps modulo 2^RAM_AW.
- Outputs are decoded from the registered state and counters only; no latches.
- In any state where an output is not listed above, it is 0: w_rf, w_ram, rd_valid, DA, SA, SB, adr, ram_adr.
- start and the input buses are ignored while busy. Captured values are used for the whole run.
- Reset at any time: state goes to IDLE, counters clear, every output goes to 0 (st_out=0, busy=0, done=0) asynchronously. An interrupted run is abandoned and does not resume.

## Timing
- Start sampled at edge 0 puts LOAD_A in cycle 1.
- Per pair: 3+MUL_LAT cycles.
- Readback: n cycles.
- done asserts in cycle n·(3+MUL_LAT)+n+1, with READBACK_EN defined.
- n_pairs==0: done in cycle 1, with no w_rf or w_ram activity.
- start held high continuously: the next run's LOAD_A comes 2 cycles after the done cycle (DONE→IDLE→LOAD_A).
- Reset dominates the clock edge; the first state change after reset deassertion requires start in IDLE.

## Configuration
- READBACK_EN defined:
  - READ_RAM phase present as described.
- READBACK_EN undefined:
  - READ_RAM is unreachable; WRITE_RAM of the last pair goes directly to DONE.
  - rd_valid is tied 0.
  - done asserts in cycle n·(3+MUL_LAT)+1.

## Test plan
- Single pair, READBACK_EN defined, defaults. Inputs adr1=1, adr2=4, ram_base=2, n_pairs=1, start pulse -> cycle 1 adr=1 DA=0 SB=1 w_rf=1; cycle 2 adr=4 DA=1; cycle 3 st_out=3; cycle 4 w_ram=1 ram_adr=2; cycle 5 rd_valid=1 ram_adr=2; cycle 6 done=1; cycle 7 st_out=0.
- Wrap-around. Inputs adr1=6, adr2=7, ram_base=14, n_pairs=3 -> A addresses 6,7,0; B addresses 7,0,1; writes to 14,15,0; readback 14,15,0; done in cycle 16.
- Zero count. n_pairs=0, start -> cycle 1 st_out=6 done=1; w_rf and w_ram never assert.
- Reset mid-run. n_pairs=4, reset raised during MULTIPLY of pair 2 -> all outputs 0 immediately and st_out=0; no further w_ram after reset falls until a new start.
- Busy lockout. start held high, adr1 changed to 5 mid-run in a 2-pair run -> run uses the captured adr1; second run's LOAD_A 2 cycles after done, using adr1=5.
- MUL_LAT=3 with READBACK_EN undefined, n_pairs=2 -> MULTIPLY lasts 3 cycles per pair, rd_valid stays 0, done in cycle 13.
